axi_wr_scheduler: RTL and testbench

AXI_WR_SCHEDULER -- requirements
Module: axi_wr_scheduler

---
 rtl/video_axi_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/axi_wr_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_axi_wr_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_axi_pkg.sv
// Shared definitions for the video AXI write path: FSM encodings, AXI burst
// constants and default burst geometry.
package video_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } wr_state_t;

    localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam int DEF_BURST_LEN    = 16;
    localparam int DEF_REGION_SHIFT = 22;
    localparam int CH_SEL_W         = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last_grant, wrapping
// modulo N_CH.
module rr_arbiter
    import video_axi_pkg::*;
#(
    parameter int N_CH = 5
) (
    input  logic [N_CH-1:0]     req,
    input  logic [CH_SEL_W-1:0] last_grant,
    output logic [CH_SEL_W-1:0] grant,
    output logic                any_req
);

    logic [CH_SEL_W-1:0] cand [N_CH];

    // cand[k] is the k-th channel in search order starting at last_grant+1
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
        assign cand[gi] = CH_SEL_W'((int'(last_grant) + 1 + gi) % N_CH);
    end

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && req[cand[k]]) begin
                grant = cand[k];
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/axi_wr_scheduler.sv
// Multi-channel video write scheduler: arbitrates buffered channels and issues
// fixed-length AXI write bursts. Optional macro: FOCUS_CH_PRIORITY_EN.
module axi_wr_scheduler
    import video_axi_pkg::*;
#(
    parameter int N_CH            = 5,
    parameter int MEM_DQ_WIDTH    = 32,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int BURST_LEN       = DEF_BURST_LEN,
    parameter int FRAME_BURSTS    = 1050,
    parameter int REGION_SHIFT    = DEF_REGION_SHIFT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            ch_req,
    input  logic [N_CH-1:0]            ch_frame_start,
    input  logic [MEM_DQ_WIDTH*8-1:0]  ch_rd_data,
    output logic [2:0]                 ch_sel,
    output logic                       ch_rd_en,
    output logic [N_CH-1:0]            ch_done,
    output logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [3:0]                 axi_awid,
    output logic [3:0]                 axi_awlen,
    output logic [2:0]                 axi_awsize,
    output logic [1:0]                 axi_awburst,
    output logic                       axi_awvalid,
    input  logic                       axi_awready,
    output logic [MEM_DQ_WIDTH*8-1:0]  axi_wdata,
    output logic [MEM_DQ_WIDTH-1:0]    axi_wstrb,
    output logic                       axi_wvalid,
    input  logic                       axi_wready,
    input  logic                       axi_wlast
);

    localparam int PTR_W = $clog2(FRAME_BURSTS);
    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);
    localparam logic [CTRL_ADDR_WIDTH-1:0] BURST_STRIDE = CTRL_ADDR_WIDTH'(BURST_LEN * 8);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FRAME_BURSTS - 1);

    wr_state_t state_reg, state_next;
    logic [CH_SEL_W-1:0]        ch_sel_reg;
    logic [CH_SEL_W-1:0]        last_grant_reg;
    logic                       grant_seen_reg;
    logic [3:0]                 beat_cnt_reg;
    logic [CTRL_ADDR_WIDTH-1:0] awaddr_reg;
    logic [3:0]                 awid_reg;
    logic [N_CH-1:0][PTR_W-1:0] wr_ptr_reg, wr_ptr_next, ptr_inc;
    logic [N_CH-1:0]            pending_reg, pending_next;
    logic [N_CH-1:0]            ch_active, ch_retire;

    // Burst end is counted locally; the memory controller's last flag is not trusted.
    logic unused_wlast;
    assign unused_wlast = axi_wlast;

    // ---------------- arbitration ----------------
    logic [N_CH-1:0]     rr_req;
    logic [CH_SEL_W-1:0] rr_grant, arb_last, grant;
    logic                rr_any, any_req, update_last, grant_fire;
    logic [PTR_W-1:0]    start_ptr;

    // Before the first grant the search begins at channel 0.
    assign arb_last   = grant_seen_reg ? last_grant_reg : CH_SEL_W'(N_CH - 1);
    assign grant_fire = (state_reg == ST_IDLE) && any_req;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req        (rr_req),
        .last_grant (arb_last),
        .grant      (rr_grant),
        .any_req    (rr_any)
    );

`ifdef FOCUS_CH_PRIORITY_EN
    logic focus_last_reg;
    logic focus_take;

    // Focus channel jumps the queue, but yields one slot to the round-robin
    // winner after each of its own bursts so the others are never starved.
    assign rr_req      = {1'b0, ch_req[N_CH-2:0]};
    assign focus_take  = ch_req[N_CH-1] && (!focus_last_reg || !rr_any);
    assign grant       = focus_take ? CH_SEL_W'(N_CH - 1) : rr_grant;
    assign any_req     = |ch_req;
    assign update_last = !focus_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            focus_last_reg <= 1'b0;
        else if (grant_fire)
            focus_last_reg <= focus_take;
    end
`else
    assign rr_req      = ch_req;
    assign grant       = rr_grant;
    assign any_req     = rr_any;
    assign update_last = 1'b1;
`endif

    // A frame start arriving with the grant restarts the channel at offset 0.
    assign start_ptr = ch_frame_start[grant] ? {PTR_W{1'b0}} : wr_ptr_reg[grant];

    // ---------------- FSM ----------------
    always_comb begin
        state_next  = state_reg;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        ch_done     = '0;
        case (state_reg)
            ST_IDLE: if (any_req) state_next = ST_AW;
            ST_AW: begin
                axi_awvalid = 1'b1;
                if (axi_awready) state_next = ST_WR;
            end
            ST_WR: begin
                axi_wvalid = 1'b1;
                if (axi_wready && beat_cnt_reg == LAST_BEAT) state_next = ST_DONE;
            end
            ST_DONE: begin
                ch_done    = N_CH'(1) << ch_sel_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ch_sel_reg     <= '0;
            last_grant_reg <= '0;
            grant_seen_reg <= 1'b0;
            beat_cnt_reg   <= '0;
            awaddr_reg     <= '0;
            awid_reg       <= '0;
            wr_ptr_reg     <= '0;
            pending_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            pending_reg <= pending_next;
            if (grant_fire) begin
                ch_sel_reg <= grant;
                awid_reg   <= 4'(grant);
                awaddr_reg <= (CTRL_ADDR_WIDTH'(grant) << REGION_SHIFT)
                              + CTRL_ADDR_WIDTH'(start_ptr) * BURST_STRIDE;
                if (update_last) begin
                    last_grant_reg <= grant;
                    grant_seen_reg <= 1'b1;
                end
            end
            if (state_reg == ST_AW && axi_awready)
                beat_cnt_reg <= '0;
            else if (state_reg == ST_WR && axi_wready)
                beat_cnt_reg <= beat_cnt_reg + 4'd1;
        end
    end

    // ---------------- per-channel frame pointers ----------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ptr
        assign ch_active[gi] = (state_reg != ST_IDLE) && (ch_sel_reg == CH_SEL_W'(gi));
        assign ch_retire[gi] = (state_reg == ST_DONE) && (ch_sel_reg == CH_SEL_W'(gi));
        assign ptr_inc[gi]   = (wr_ptr_reg[gi] == PTR_LAST) ? {PTR_W{1'b0}}
                                                            : wr_ptr_reg[gi] + 1'b1;
        // A frame start seen mid-burst is deferred so the issued address stays valid.
        assign wr_ptr_next[gi] =
            ch_retire[gi] ? ((pending_reg[gi] || ch_frame_start[gi]) ? {PTR_W{1'b0}} : ptr_inc[gi]) :
            (ch_frame_start[gi] && !ch_active[gi]) ? {PTR_W{1'b0}} : wr_ptr_reg[gi];
        assign pending_next[gi] =
            ch_retire[gi] ? 1'b0 :
            (ch_frame_start[gi] && ch_active[gi]) ? 1'b1 : pending_reg[gi];
    end

    // ---------------- outputs ----------------
    assign ch_sel      = ch_sel_reg;
    assign ch_rd_en    = axi_wvalid & axi_wready;
    assign axi_awaddr  = awaddr_reg;
    assign axi_awid    = awid_reg;
    assign axi_awlen   = LAST_BEAT;
    assign axi_awsize  = AXI_SIZE_32B;
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_wdata   = ch_rd_data;
    assign axi_wstrb   = '1;

endmodule

// File: tb/tb_axi_wr_scheduler.sv
// Directed bench for axi_wr_scheduler; expected grant orders follow
// FOCUS_CH_PRIORITY_EN when it is defined.
module tb_axi_wr_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   ch_req;
    logic [4:0]   ch_frame_start;
    logic [255:0] ch_rd_data;
    logic [2:0]   ch_sel;
    logic         ch_rd_en;
    logic [4:0]   ch_done;
    logic [27:0]  axi_awaddr;
    logic [3:0]   axi_awid;
    logic [3:0]   axi_awlen;
    logic [2:0]   axi_awsize;
    logic [1:0]   axi_awburst;
    logic         axi_awvalid;
    logic         axi_awready;
    logic [255:0] axi_wdata;
    logic [31:0]  axi_wstrb;
    logic         axi_wvalid;
    logic         axi_wready;
    logic         axi_wlast;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [27:0] addr;
        logic [3:0]  id;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] strb;
        int          pops;
        logic [4:0]  done_v;
        bit          aw_stable;
        bit          wvalid_ok;
        bit          wdata_ok;
        bit          timeout;
    } burst_obs_t;

    axi_wr_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .ch_req         (ch_req),
        .ch_frame_start (ch_frame_start),
        .ch_rd_data     (ch_rd_data),
        .ch_sel         (ch_sel),
        .ch_rd_en       (ch_rd_en),
        .ch_done        (ch_done),
        .axi_awaddr     (axi_awaddr),
        .axi_awid       (axi_awid),
        .axi_awlen      (axi_awlen),
        .axi_awsize     (axi_awsize),
        .axi_awburst    (axi_awburst),
        .axi_awvalid    (axi_awvalid),
        .axi_awready    (axi_awready),
        .axi_wdata      (axi_wdata),
        .axi_wstrb      (axi_wstrb),
        .axi_wvalid     (axi_wvalid),
        .axi_wready     (axi_wready),
        .axi_wlast      (axi_wlast)
    );

    always #5 clk = ~clk;

    // Show-ahead buffer model: each pop exposes a new word.
    logic [31:0] pop_cnt = 32'd0;
    always @(posedge clk) if (ch_rd_en) pop_cnt <= pop_cnt + 32'd1;
    assign ch_rd_data = {8{pop_cnt}};

    task automatic do_reset();
        rst = 1'b1; ch_req = '0; ch_frame_start = '0; axi_awready = 1'b0; axi_wready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one burst and records what was observed; comparisons are done by callers.
    task automatic do_burst(input bit toggle, input int aw_delay, input bit drop_req,
                            input int fs_beat, output burst_obs_t o);
        bit seen, phase, fired, prev_stall;
        logic [255:0] prev_wdata;
        o.addr = '0; o.id = '0; o.len = '0; o.size = '0; o.burst = '0; o.strb = '0;
        o.pops = 0; o.done_v = '0; o.aw_stable = 1'b1; o.wvalid_ok = 1'b1;
        o.wdata_ok = 1'b1; o.timeout = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); axi_awready = 1'b0; #1;
            seen = (axi_awvalid === 1'b1);
        end
        if (!seen) begin
            o.timeout = 1'b1;
            $display("burst: no AW issued");
            return;
        end
        o.addr = axi_awaddr; o.id = axi_awid; o.len = axi_awlen;
        o.size = axi_awsize; o.burst = axi_awburst; o.strb = axi_wstrb;
        if (drop_req) ch_req = '0;
        for (int d = 0; d < aw_delay; d++) begin
            @(negedge clk); #1;
            if (axi_awvalid !== 1'b1 || axi_awaddr !== o.addr || axi_awid !== o.id) o.aw_stable = 1'b0;
        end
        axi_awready = 1'b1;
        phase = 1'b1; fired = 1'b0; prev_stall = 1'b0; prev_wdata = '0;
        o.timeout = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            axi_awready = 1'b0; ch_frame_start = '0;
            axi_wready = toggle ? phase : 1'b1;
            phase = ~phase;
            if (fs_beat >= 0 && !fired && o.pops == fs_beat) begin
                ch_frame_start = 5'b1 << ch_sel;
                fired = 1'b1;
            end
            #1;
            if (ch_rd_en === 1'b1) o.pops++;
            if (|ch_done) begin o.done_v = ch_done; o.timeout = 1'b0; break; end
            if (axi_wvalid !== 1'b1) o.wvalid_ok = 1'b0;
            if (axi_wdata !== ch_rd_data) o.wdata_ok = 1'b0;
            if (prev_stall && axi_wdata !== prev_wdata) o.wdata_ok = 1'b0;
            prev_stall = !axi_wready;
            prev_wdata = axi_wdata;
        end
        if (ch_frame_start != '0) begin @(negedge clk); ch_frame_start = '0; end
        $display("burst id=%0d addr=%0h pops=%0d done=%b", o.id, o.addr, o.pops, o.done_v);
    endtask

    task automatic test_reset();
        rst = 1'b1; ch_req = 5'b11111; ch_frame_start = '0; axi_awready = 1'b1; axi_wready = 1'b1;
        axi_wlast = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid: got %b expected 0", axi_awvalid); end
        checks++; if (axi_wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b expected 0", axi_wvalid); end
        checks++; if (ch_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", ch_rd_en); end
        checks++; if (ch_done !== 5'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", ch_done); end
        checks++; if ({axi_awaddr, axi_awid, ch_sel} !== 35'b0) begin errors++; $display("FAIL reset_addr_id_sel: got %0h/%0h/%0h expected 0", axi_awaddr, axi_awid, ch_sel); end
        ch_req = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL idle_no_req: got awvalid %b expected 0", axi_awvalid); end
        $display("reset test done");
    endtask

    task automatic test_single();
        burst_obs_t o;
        do_reset();
        ch_req = 5'b00001;
        do_burst(1'b0, 3, 1'b0, -1, o);
        checks++; if (o.timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b expected 0", o.timeout); end
        checks++; if (o.addr !== 28'h0) begin errors++; $display("FAIL single_awaddr: got %0h expected 0", o.addr); end
        checks++; if (o.id !== 4'd0) begin errors++; $display("FAIL single_awid: got %0d expected 0", o.id); end
        checks++; if ({o.len, o.size, o.burst} !== {4'hF, 3'b101, 2'b01}) begin errors++; $display("FAIL single_aw_fields: got len %0h size %b burst %b expected f 101 01", o.len, o.size, o.burst); end
        checks++; if (o.strb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL single_wstrb: got %0h expected ffffffff", o.strb); end
        checks++; if (o.aw_stable !== 1'b1) begin errors++; $display("FAIL single_aw_hold: got %b expected 1", o.aw_stable); end
        checks++; if (o.pops !== 16) begin errors++; $display("FAIL single_pops: got %0d expected 16", o.pops); end
        checks++; if (o.done_v !== 5'b00001) begin errors++; $display("FAIL single_done: got %b expected 00001", o.done_v); end
        checks++; if ({o.wvalid_ok, o.wdata_ok} !== 2'b11) begin errors++; $display("FAIL single_wchan: got %b expected 11", {o.wvalid_ok, o.wdata_ok}); end
        // Second burst drops ch_req right after AW is issued; it must still complete.
        do_burst(1'b0, 0, 1'b1, -1, o);
        checks++; if (o.addr !== 28'd128) begin errors++; $display("FAIL second_awaddr: got %0h expected 80", o.addr); end
        checks++; if (o.pops !== 16 || o.done_v !== 5'b00001) begin errors++; $display("FAIL req_drop_burst: got pops %0d done %b expected 16 00001", o.pops, o.done_v); end
        repeat (4) @(negedge clk);
        #1;
        checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL after_drop_idle: got awvalid %b expected 0", axi_awvalid); end
    endtask

    task automatic test_round_robin();
        burst_obs_t o;
        logic [3:0]  exp_id [6];
        logic [27:0] exp_addr [6];
        do_reset();
`ifdef FOCUS_CH_PRIORITY_EN
        exp_id = '{4'd4, 4'd0, 4'd4, 4'd1, 4'd4, 4'd0};
        exp_addr = '{28'h1000000, 28'h0, 28'h1000080, 28'h0400000, 28'h1000100, 28'h80};
        ch_req = 5'b10011;
`else
        exp_id = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        exp_addr = '{28'h0, 28'h0400000, 28'h0800000, 28'h0C00000, 28'h1000000, 28'h80};
        ch_req = 5'b11111;
`endif
        for (int k = 0; k < 6; k++) begin
            do_burst(1'b0, 0, 1'b0, -1, o);
            checks++; if (o.id !== exp_id[k] || o.timeout) begin errors++; $display("FAIL rr_grant_%0d: got id %0d expected %0d", k, o.id, exp_id[k]); end
            checks++; if (o.addr !== exp_addr[k]) begin errors++; $display("FAIL rr_addr_%0d: got %0h expected %0h", k, o.addr, exp_addr[k]); end
        end
        ch_req = '0;
    endtask

    task automatic test_wready_toggle();
        burst_obs_t o;
        do_reset();
        ch_req = 5'b01000;
        do_burst(1'b1, 0, 1'b1, -1, o);
        checks++; if (o.addr !== 28'hC00000 || o.id !== 4'd3) begin errors++; $display("FAIL toggle_aw: got %0h/%0d expected c00000/3", o.addr, o.id); end
        checks++; if (o.pops !== 16) begin errors++; $display("FAIL toggle_pops: got %0d expected 16", o.pops); end
        checks++; if (o.wdata_ok !== 1'b1) begin errors++; $display("FAIL toggle_wdata_stable: got %b expected 1", o.wdata_ok); end
        checks++; if (o.wvalid_ok !== 1'b1) begin errors++; $display("FAIL toggle_wvalid_held: got %b expected 1", o.wvalid_ok); end
        checks++; if (o.done_v !== 5'b01000) begin errors++; $display("FAIL toggle_done: got %b expected 01000", o.done_v); end
    endtask

    task automatic test_frame_start();
        burst_obs_t o;
        do_reset();
        ch_req = 5'b00100;
        do_burst(1'b0, 0, 1'b0, 5, o);
        checks++; if (o.addr !== 28'h800000) begin errors++; $display("FAIL fs_first_addr: got %0h expected 800000", o.addr); end
        do_burst(1'b0, 0, 1'b0, -1, o);
        checks++; if (o.addr !== 28'h800000) begin errors++; $display("FAIL fs_midburst_clear: got %0h expected 800000", o.addr); end
        do_burst(1'b0, 0, 1'b0, -1, o);
        checks++; if (o.addr !== 28'h800080) begin errors++; $display("FAIL fs_resume_incr: got %0h expected 800080", o.addr); end
        ch_req = '0;
        repeat (2) @(negedge clk);
        ch_frame_start = 5'b00100;
        @(negedge clk);
        ch_frame_start = '0;
        ch_req = 5'b00100;
        do_burst(1'b0, 0, 1'b1, -1, o);
        checks++; if (o.addr !== 28'h800000) begin errors++; $display("FAIL fs_idle_clear: got %0h expected 800000", o.addr); end
    endtask

    task automatic test_wrap_and_reset();
        burst_obs_t o;
        int bad, n;
        bit seen, late;
        do_reset();
        ch_req = 5'b00010;
        bad = 0;
        for (int k = 0; k < 1050; k++) begin
            do_burst(1'b0, 0, 1'b0, -1, o);
            if (o.timeout || o.addr !== 28'(28'h400000 + k * 128)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_ramp: got %0d bad bursts expected 0", bad); end
        do_burst(1'b0, 0, 1'b0, -1, o);
        checks++; if (o.addr !== 28'h400000) begin errors++; $display("FAIL wrap_addr: got %0h expected 400000", o.addr); end
        // Next burst is abandoned by reset after beat 7.
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); axi_awready = 1'b0; #1;
            seen = (axi_awvalid === 1'b1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL abort_aw_seen: got 0 expected 1"); end
        axi_awready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 7; c++) begin
            @(negedge clk); axi_awready = 1'b0; axi_wready = 1'b1; #1;
            if (ch_rd_en === 1'b1) n++;
        end
        checks++; if (n !== 7) begin errors++; $display("FAIL abort_beats: got %0d expected 7", n); end
        @(negedge clk);
        rst = 1'b1; ch_req = '0;
        #1;
        checks++; if ({axi_awvalid, axi_wvalid, ch_rd_en, ch_done, axi_awaddr, axi_awid, ch_sel} !== 43'b0) begin
            errors++; $display("FAIL abort_outputs: got aw %b w %b rd %b done %b addr %0h id %0h sel %0h expected all 0",
                axi_awvalid, axi_wvalid, ch_rd_en, ch_done, axi_awaddr, axi_awid, ch_sel);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        late = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (|ch_done || axi_awvalid || axi_wvalid) late = 1'b1;
        end
        checks++; if (late !== 1'b0) begin errors++; $display("FAIL abort_no_done: got activity %b expected 0", late); end
        $display("wrap and abort test done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wready_toggle();
        test_frame_start();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
